// File: rtl/wb_pipelined_memory.sv
// Pipelined Wishbone word memory with byte enables, fixed read latency, range errors
// and a hardware clear sweep that runs after reset or on request.
module wb_pipelined_memory #(
  parameter int DW                = 32,
  parameter int AW                = 4,
  parameter int DEPTH             = 1 << AW,
  parameter int LATENCY           = 2,
  parameter logic [DW-1:0] INIT_VAL = {DW{1'b1}}
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  input  logic            i_clear,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic            o_wb_err,
  output logic [DW-1:0]   o_wb_data,
  output logic            o_busy
);
  localparam int SW = DW / 8;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_W  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          stall, sweep_en;
  logic          accept, in_range, wr_en, rd_en, done;
  logic [DW-1:0] rd_word, data_out;
  logic [LATENCY-1:0] valid_reg, err_reg, read_reg;

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == LAST_W) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall    = (state_reg == CLEAR);
    sweep_en = (state_reg == CLEAR);
  end

  assign o_wb_stall = stall;
  assign o_busy     = stall;

  assign accept   = i_wb_cyc & i_wb_stb & ~stall;
  assign in_range = ({1'b0, i_wb_addr} < DEPTH_W);
  assign wr_en    = accept & i_wb_we & in_range;
  assign rd_en    = accept & ~i_wb_we & in_range;

  // One block RAM per byte lane; the sweep owns the write port while it runs.
  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;

      always_ff @(posedge i_clk) begin
        if (sweep_en)
          lane_mem[cnt_reg] <= INIT_VAL[8*gi +: 8];
        else if (wr_en && i_wb_sel[gi])
          lane_mem[i_wb_addr] <= i_wb_data[8*gi +: 8];
        if (rd_en)
          lane_rd_reg <= lane_mem[i_wb_addr];
      end

      assign rd_word[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

  // Control pipeline; dropping cyc kills everything in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_reg <= '0;
      err_reg   <= '0;
      read_reg  <= '0;
    end else begin
      valid_reg[0] <= accept;
      err_reg[0]   <= ~in_range;
      read_reg[0]  <= ~i_wb_we;
      for (int k = 1; k < LATENCY; k++) begin
        valid_reg[k] <= valid_reg[k-1] & i_wb_cyc;
        err_reg[k]   <= err_reg[k-1];
        read_reg[k]  <= read_reg[k-1];
      end
    end
  end

  // Read data trails the RAM output register by LATENCY-1 cycles.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign data_out = rd_word;
    end else begin : g_latn
      logic [LATENCY-2:0][DW-1:0] dly_reg;

      always_ff @(posedge i_clk) begin
        dly_reg[0] <= rd_word;
        for (int k = 1; k < LATENCY - 1; k++)
          dly_reg[k] <= dly_reg[k-1];
      end

      assign data_out = dly_reg[LATENCY-2];
    end
  endgenerate

  assign done      = valid_reg[LATENCY-1] & i_wb_cyc;
  assign o_wb_ack  = done & ~err_reg[LATENCY-1];
  assign o_wb_err  = done & err_reg[LATENCY-1];
  assign o_wb_data = (o_wb_ack && read_reg[LATENCY-1]) ? data_out : '0;

endmodule
